// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the issue stage and the muldiv unit
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wb_en;

   modport master (
      output start, op, rs1_data, rs2_data, rd_in, flush,
      input  busy, done, result, rd_out, wb_en
   );

   modport slave (
      input  start, op, rs1_data, rs2_data, rd_in, flush,
      output busy, done, result, rd_out, wb_en
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [XLEN-1:0]  L_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(XLEN-1);

   state_t            r_state;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_b;
   logic [2*XLEN-1:0] r_acc;
   logic              r_neg;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd_out;
   logic              r_busy;
   logic              r_done;
   logic              r_wb_en;

   logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic              w_div_zero, w_ovf;
   logic [XLEN-1:0]   w_special_res;
   logic              w_neg_start;

   // Operand decode at issue: magnitudes, sign flag and the two divide corner cases
   always_comb begin
      w_a_signed    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
      w_b_signed    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
      w_a_neg       = w_a_signed && bus.rs1_data[XLEN-1];
      w_b_neg       = w_b_signed && bus.rs2_data[XLEN-1];
      w_a_mag       = w_a_neg ? -bus.rs1_data : bus.rs1_data;
      w_b_mag       = w_b_neg ? -bus.rs2_data : bus.rs2_data;
      w_div_zero    = bus.op[2] && (bus.rs2_data == '0);
      w_ovf         = bus.op[2] && !bus.op[0] && (bus.rs1_data == L_MIN) && (bus.rs2_data == '1);
      w_special_res = w_div_zero ? (bus.op[1] ? bus.rs1_data : '1)
                                 : (bus.op[1] ? '0 : L_MIN);
      w_neg_start   = (bus.op[2] && bus.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
   end

   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_div_next;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo, w_rem;
   logic [XLEN-1:0]   w_final;

   // r_acc holds {hi, lo}: product high/multiplier for MUL*, remainder/quotient for DIV*
   always_comb begin
      w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
      w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
      w_diff     = w_rem_sh - {1'b0, r_b};
      w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};
      w_prod     = r_neg ? -w_mul_next : w_mul_next;
      w_quo      = w_div_next[XLEN-1:0];
      w_rem      = w_div_next[2*XLEN-1:XLEN];
      w_final    = '0;
      if (!r_op[2]) begin
         w_final = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      end else if (r_op[1]) begin
         w_final = r_neg ? -w_rem : w_rem;
      end else begin
         w_final = r_neg ? -w_quo : w_quo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_rd     <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rd_out <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wb_en  <= 1'b0;
      end else if (bus.flush) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wb_en  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done  <= 1'b0;
               r_wb_en <= 1'b0;
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_rd   <= bus.rd_in;
                  r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                  r_b    <= w_b_mag;
                  r_neg  <= w_neg_start;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (w_div_zero || w_ovf) begin
                     r_result <= w_special_res;
                     r_rd_out <= bus.rd_in;
                     r_wb_en  <= (bus.rd_in != 5'd0);
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_acc <= r_op[2] ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == L_LAST) begin
                  r_result <= w_final;
                  r_rd_out <= r_rd;
                  r_wb_en  <= (r_rd != 5'd0);
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_wb_en <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd_out;
   assign bus.wb_en  = r_wb_en;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   muldiv_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_in    = rd;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_cyc);
      int cyc;
      start_op(op, a, b, rd);
      cyc = 1;
      while (!bus.done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, " result"}, bus.result, exp_res);
      chk({tag, " wb_en"}, {31'd0, bus.wb_en}, {31'd0, rd != 5'd0});
      chk({tag, " rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
      @(negedge clk);
      chk({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      int n_done;
      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.op       = 3'd0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.rd_in    = '0;
      bus.flush    = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy",   {31'd0, bus.busy},  32'd0);
      chk("reset done",   {31'd0, bus.done},  32'd0);
      chk("reset wb_en",  {31'd0, bus.wb_en}, 32'd0);
      chk("reset result", bus.result,         32'd0);
      chk("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
      rst_n = 1'b1;

      run_op("MUL 7*-3",    3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
      run_op("MULH min^2",  3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
      run_op("MULHU max^2", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
      run_op("MULHSU -1*2", 3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, 33);
      run_op("MUL lo max^2",3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001, 33);
      run_op("DIV -7/2",    3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD, 33);
      run_op("REM -7/2",    3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF, 33);
      run_op("DIVU 100/7",  3'd5, 32'd100,      32'd7,        5'd10, 32'd14,       33);
      run_op("REMU 100/7",  3'd7, 32'd100,      32'd7,        5'd11, 32'd2,        33);
      run_op("DIV x/0",     3'd4, 32'h00000055, 32'h00000000, 5'd12, 32'hFFFFFFFF, 1);
      run_op("DIVU x/0",    3'd5, 32'h00000005, 32'h00000000, 5'd13, 32'hFFFFFFFF, 1);
      run_op("REM x/0",     3'd6, 32'h00001234, 32'h00000000, 5'd14, 32'h00001234, 1);
      run_op("REMU x/0",    3'd7, 32'h87654321, 32'h00000000, 5'd15, 32'h87654321, 1);
      run_op("DIV ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
      run_op("REM ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 1);
      run_op("MUL rd0",     3'd0, 32'd3,        32'd4,        5'd0,  32'd12,       33);

      // start pulses while busy and in the done cycle must not be accepted
      start_op(3'd5, 32'd100, 32'd7, 5'd3);
      n_done = 0;
      for (int i = 1; i < 45; i++) begin
         bus.start = (i == 5) || (i == 20) || bus.done;
         bus.op       = 3'd0;
         bus.rs1_data = 32'd2;
         bus.rs2_data = 32'd2;
         bus.rd_in    = 5'd9;
         if (bus.done) n_done++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("busy-start done count", 32'(n_done), 32'd1);
      chk("busy-start result", bus.result, 32'd14);
      chk("busy-start rd_out", {27'd0, bus.rd_out}, 32'd3);
      chk("busy-start idle", {31'd0, bus.busy}, 32'd0);

      // flush in cycle 10 of a DIV
      start_op(3'd4, 32'd100, 32'd7, 5'd4);
      repeat (9) @(negedge clk);
      chk("flush pre busy", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush busy", {31'd0, bus.busy}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.wb_en) n_done++;
         @(negedge clk);
      end
      chk("flush no done", 32'(n_done), 32'd0);
      chk("flush result kept", bus.result, 32'd14);
      chk("flush rd_out kept", {27'd0, bus.rd_out}, 32'd3);

      // asynchronous reset in cycle 20 of a MUL
      start_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset busy",   {31'd0, bus.busy},   32'd0);
      chk("midreset done",   {31'd0, bus.done},   32'd0);
      chk("midreset wb_en",  {31'd0, bus.wb_en},  32'd0);
      chk("midreset result", bus.result,          32'd0);
      chk("midreset rd_out", {27'd0, bus.rd_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) n_done++;
         @(negedge clk);
      end
      chk("midreset no done", 32'(n_done), 32'd0);

      run_op("REMU post-reset", 3'd7, 32'd1000, 32'd33, 5'd31, 32'd10, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
